// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory and hands one
// word at a time to decode over a valid/ready handshake.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          MEM_BYTES = 256
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [31:0] IAddr,
  output logic        RW,
  input  logic [31:0] IDataIn,
  input  logic        PCWre,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddr,
  output logic [31:0] InstOut,
  output logic [31:0] PCOut,
  output logic        InstValid,
  input  logic        InstReady,
  output logic        AddrErr
);

  typedef enum logic [1:0] {START, FETCH, HOLD, ERROR} state_t;

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        redirect_ok;
  logic        can_fetch;

  assign next_pc     = (pc + 32'd4) & ADDR_MASK;
  assign redirect_ok = (RedirectAddr[1:0] == 2'b00) && (RedirectAddr < 32'(MEM_BYTES));
  // A new word may be captured when the buffer is empty or being drained.
  assign can_fetch   = PCWre && (!InstValid || InstReady);
  assign IAddr       = pc;
  assign RW          = 1'b1;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state     <= START;
      pc        <= RESET_PC;
      InstOut   <= 32'h0;
      PCOut     <= 32'h0;
      InstValid <= 1'b0;
      AddrErr   <= 1'b0;
    end else begin
      case (state)
        START: state <= FETCH;
        FETCH, HOLD: begin
          if (Redirect) begin
            InstValid <= 1'b0;
            if (redirect_ok) begin
              pc    <= RedirectAddr;
              state <= FETCH;
            end else begin
              AddrErr <= 1'b1;
              state   <= ERROR;
            end
          end else if (can_fetch) begin
            InstOut   <= IDataIn;
            PCOut     <= pc;
            InstValid <= 1'b1;
            pc        <= next_pc;
            state     <= FETCH;
          end else if (InstValid && !InstReady) begin
            state <= HOLD;
          end else begin
            // Halted: a presented word drains, nothing new is fetched.
            InstValid <= 1'b0;
            state     <= FETCH;
          end
        end
        ERROR: state <= ERROR;
        default: state <= START;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a 256-byte memory model feeds
// IDataIn and expected (word, address) pairs are queued ahead of each capture.
module tb_instruction_fetch_unit;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] IAddr;
  logic        RW;
  logic [31:0] IDataIn;
  logic        PCWre = 1'b1;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectAddr = 32'h0;
  logic [31:0] InstOut;
  logic [31:0] PCOut;
  logic        InstValid;
  logic        InstReady = 1'b1;
  logic        AddrErr;

  logic [31:0] mem [64];
  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;

  assign IDataIn = mem[IAddr[7:2]];

  instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(256)) dut (
    .CLK(CLK), .Reset(Reset), .IAddr(IAddr), .RW(RW), .IDataIn(IDataIn),
    .PCWre(PCWre), .Redirect(Redirect), .RedirectAddr(RedirectAddr),
    .InstOut(InstOut), .PCOut(PCOut), .InstValid(InstValid),
    .InstReady(InstReady), .AddrErr(AddrErr)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] addr);
    exp_t e;
    e.inst = mem[addr[7:2]];
    e.pc   = addr;
    q.push_back(e);
  endtask

  task automatic test_reset();
    Reset = 1'b0; PCWre = 1'b1; Redirect = 1'b0; InstReady = 1'b1;
    tick(); tick();
    checks++;
    if ({RW, InstValid, InstOut, PCOut, IAddr, AddrErr} !== {1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset: rw=%b v=%b inst=%h pc=%h iaddr=%h err=%b want 1/0/0/0/0/0",
               RW, InstValid, InstOut, PCOut, IAddr, AddrErr);
    end
  endtask

  task automatic test_sequential();
    exp_t e;
    Reset = 1'b1;
    tick();
    checks++;
    if (InstValid !== 1'b0) begin
      errors++; $display("FAIL seq_start: valid=%b want 0", InstValid);
    end
    for (int i = 0; i < 4; i++) push(32'(i * 4));
    for (int i = 0; i < 4; i++) begin
      tick();
      e = q.pop_front();
      checks++;
      if ({InstValid, InstOut, PCOut} !== {1'b1, e.inst, e.pc}) begin
        errors++;
        $display("FAIL seq%0d: got %b/%h/%h want 1/%h/%h", i, InstValid, InstOut, PCOut, e.inst, e.pc);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    Reset = 1'b0; tick(); Reset = 1'b1; tick();
    push(32'h0); push(32'h4);
    for (int i = 0; i < 2; i++) begin
      tick();
      e = q.pop_front();
      checks++;
      if ({InstValid, InstOut, PCOut} !== {1'b1, e.inst, e.pc}) begin
        errors++;
        $display("FAIL stall_pre%0d: got %b/%h/%h want 1/%h/%h", i, InstValid, InstOut, PCOut, e.inst, e.pc);
      end
    end
    InstReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({InstValid, InstOut, PCOut, IAddr} !== {1'b1, 32'h20020007, 32'h4, 32'h8}) begin
        errors++;
        $display("FAIL stall_hold%0d: got %b/%h/%h/%h want 1/20020007/4/8", i, InstValid, InstOut, PCOut, IAddr);
      end
    end
    InstReady = 1'b1;
    push(32'h8);
    tick();
    e = q.pop_front();
    checks++;
    if ({InstValid, InstOut, PCOut} !== {1'b1, e.inst, e.pc}) begin
      errors++;
      $display("FAIL stall_release: got %b/%h/%h want 1/%h/%h", InstValid, InstOut, PCOut, e.inst, e.pc);
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    Redirect = 1'b1; RedirectAddr = 32'h40;
    tick();
    Redirect = 1'b0;
    checks++;
    if ({InstValid, IAddr} !== {1'b0, 32'h40}) begin
      errors++; $display("FAIL redir_squash: got %b/%h want 0/40", InstValid, IAddr);
    end
    push(32'h40); push(32'h44);
    for (int i = 0; i < 2; i++) begin
      tick();
      e = q.pop_front();
      checks++;
      if ({InstValid, InstOut, PCOut} !== {1'b1, e.inst, e.pc}) begin
        errors++;
        $display("FAIL redir%0d: got %b/%h/%h want 1/%h/%h", i, InstValid, InstOut, PCOut, e.inst, e.pc);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    Redirect = 1'b1; RedirectAddr = 32'hFC;
    tick();
    Redirect = 1'b0;
    checks++;
    if ({InstValid, IAddr} !== {1'b0, 32'hFC}) begin
      errors++; $display("FAIL wrap_redir: got %b/%h want 0/fc", InstValid, IAddr);
    end
    push(32'hFC); push(32'h0); push(32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      e = q.pop_front();
      checks++;
      if ({InstValid, InstOut, PCOut, AddrErr} !== {1'b1, e.inst, e.pc, 1'b0}) begin
        errors++;
        $display("FAIL wrap%0d: got %b/%h/%h err=%b want 1/%h/%h err=0",
                 i, InstValid, InstOut, PCOut, AddrErr, e.inst, e.pc);
      end
    end
  endtask

  task automatic test_illegal(input logic [31:0] bad, input logic [31:0] held);
    Redirect = 1'b1; RedirectAddr = bad;
    tick();
    Redirect = 1'b0;
    checks++;
    if ({AddrErr, InstValid, IAddr} !== {1'b1, 1'b0, held}) begin
      errors++;
      $display("FAIL illegal_%h: got err=%b v=%b iaddr=%h want 1/0/%h", bad, AddrErr, InstValid, IAddr, held);
    end
    Redirect = 1'b1; RedirectAddr = 32'h10;
    tick();
    Redirect = 1'b0;
    tick();
    checks++;
    if ({AddrErr, InstValid, IAddr} !== {1'b1, 1'b0, held}) begin
      errors++;
      $display("FAIL error_absorb_%h: got err=%b v=%b iaddr=%h want 1/0/%h", bad, AddrErr, InstValid, IAddr, held);
    end
    Reset = 1'b0;
    tick();
    checks++;
    if ({AddrErr, InstValid, IAddr} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL error_reset_%h: got err=%b v=%b iaddr=%h want 0/0/0", bad, AddrErr, InstValid, IAddr);
    end
    Reset = 1'b1;
  endtask

  task automatic test_halt();
    exp_t e;
    Reset = 1'b0; tick(); Reset = 1'b1; InstReady = 1'b1;
    tick();
    PCWre = 1'b0;
    tick();
    checks++;
    if ({InstValid, IAddr} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL halt_idle: got %b/%h want 0/0", InstValid, IAddr);
    end
    PCWre = 1'b1;
    push(32'h0);
    tick();
    e = q.pop_front();
    checks++;
    if ({InstValid, InstOut, PCOut} !== {1'b1, e.inst, e.pc}) begin
      errors++;
      $display("FAIL halt_first: got %b/%h/%h want 1/%h/%h", InstValid, InstOut, PCOut, e.inst, e.pc);
    end
    InstReady = 1'b0; PCWre = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({InstValid, InstOut, PCOut, IAddr} !== {1'b1, 32'h20010005, 32'h0, 32'h4}) begin
        errors++;
        $display("FAIL halt_hold%0d: got %b/%h/%h/%h want 1/20010005/0/4", i, InstValid, InstOut, PCOut, IAddr);
      end
    end
    Reset = 1'b0;
    tick();
    checks++;
    if ({InstValid, InstOut, PCOut, IAddr, RW} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL halt_reset: got %b/%h/%h/%h rw=%b want 0/0/0/0 rw=1", InstValid, InstOut, PCOut, IAddr, RW);
    end
    Reset = 1'b1; PCWre = 1'b1; InstReady = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i * 4);
    mem[0] = 32'h20010005;
    mem[1] = 32'h20020007;
    mem[2] = 32'h00221820;
    mem[3] = 32'hFC000000;

    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_illegal(32'h42, 32'h8);
    tick(); tick();
    test_illegal(32'h100, 32'h4);
    test_halt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
